// File: rtl/evr_sequence_recorder_pkg.sv
// Constants and encodings shared between the EVG sequencer and the EVR sequence recorder.
package evr_sequence_recorder_pkg;

    localparam int SEQUENCE_GAP_WIDTH = 28;
    localparam logic [7:0] END_OF_TABLE_EVENT_CODE = 8'h7F;
    localparam logic [7:0] NULL_EVENT_CODE = 8'h00;
    localparam logic [SEQUENCE_GAP_WIDTH-1:0] SEQUENCE_GAP_MAX = '1;

    typedef enum logic [1:0] {
        CSR_CONTROL          = 2'h0,
        CSR_SET_READ_ADDRESS = 2'h1,
        CSR_SET_TRIGGER      = 2'h2,
        CSR_RESERVED         = 2'h3
    } csr_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_RECORDING = 2'd2,
        ST_DONE      = 2'd3
    } rec_state_e;

endpackage

// File: rtl/evr_sequence_recorder_if.sv
// CSR and event-stream bundle of the sequence recorder.
interface evr_sequence_recorder_if #(
    parameter int EVENTCODE_WIDTH = 8
);
    // eventTVALID qualifies eventTDATA for exactly one cycle; there is no ready, the
    // recorder must accept every valid code. csrStrobe likewise qualifies csrData.
    logic                       csrStrobe;
    logic [31:0]                csrData;
    logic [31:0]                status;
    logic [31:0]                readback;
    logic [EVENTCODE_WIDTH-1:0] eventTDATA;
    logic                       eventTVALID;
    logic                       recordDone;

    modport master (
        output csrStrobe, csrData, eventTDATA, eventTVALID,
        input  status, readback, recordDone
    );

    modport slave (
        input  csrStrobe, csrData, eventTDATA, eventTVALID,
        output status, readback, recordDone
    );
endinterface

// File: rtl/evr_sequence_recorder_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port, no reset.
module evr_recorder_ram #(
    parameter int DEPTH  = 2048,
    parameter int WIDTH  = 36,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/evr_sequence_recorder.sv
// Receive-side event sequence recorder: after arming and a trigger code it stores
// {gap, event} entries in the same format as the sequencer table.
module evr_sequence_recorder
    import evr_sequence_recorder_pkg::*;
#(
    parameter int SEQUENCE_RAM_CAPACITY = 2048,
    parameter int EVENTCODE_WIDTH       = 8,
    parameter     DEBUG                 = "false"
) (
    input  logic                    evrRxClk,
    input  logic                    evrRxRst_n,
    evr_sequence_recorder_if.slave  bus
);
    localparam int ADDR_W  = $clog2(SEQUENCE_RAM_CAPACITY);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int ENTRY_W = SEQUENCE_GAP_WIDTH + EVENTCODE_WIDTH;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SEQUENCE_RAM_CAPACITY - 1);

    (* mark_debug = DEBUG *) rec_state_e                  r_state;
    (* mark_debug = DEBUG *) logic [CNT_W-1:0]            r_entry_count;
    (* mark_debug = DEBUG *) logic [SEQUENCE_GAP_WIDTH-1:0] r_gap_counter;
    logic [EVENTCODE_WIDTH-1:0] r_trigger_code;
    logic                       r_full;
    logic                       r_gap_saturated;
    logic [ADDR_W-1:0]          r_read_address;
    logic                       r_read_select;
    logic [31:0]                r_status;
    logic [31:0]                r_readback;
    logic                       r_record_done;

    rec_state_e                 w_state_next;
    csr_cmd_e                   w_cmd;
    logic                       w_arm;
    logic                       w_disarm;
    logic                       w_trigger_hit;
    logic                       w_recordable;
    logic                       w_last_slot;
    logic                       w_end_code;
    logic                       w_start;
    logic                       w_first;
    logic                       w_record;
    logic                       w_terminate;
    logic                       w_we;
    logic [ADDR_W-1:0]          w_waddr;
    logic [ENTRY_W-1:0]         w_wdata;
    logic [ENTRY_W-1:0]         w_ram_rdata;
    logic                       w_csr_unused;

    assign w_cmd         = csr_cmd_e'(bus.csrData[31:30]);
    assign w_disarm      = bus.csrStrobe && (w_cmd == CSR_CONTROL) && bus.csrData[1];
    assign w_arm         = bus.csrStrobe && (w_cmd == CSR_CONTROL) && bus.csrData[0] && !bus.csrData[1];
    assign w_trigger_hit = bus.eventTVALID && (bus.eventTDATA == r_trigger_code);
    assign w_recordable  = bus.eventTVALID && (bus.eventTDATA != EVENTCODE_WIDTH'(NULL_EVENT_CODE));
    assign w_end_code    = (bus.eventTDATA == EVENTCODE_WIDTH'(END_OF_TABLE_EVENT_CODE));
    assign w_last_slot   = (r_entry_count == LAST_SLOT);
    assign w_csr_unused  = &{1'b0, bus.csrData};

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_first      = 1'b0;
        w_record     = 1'b0;
        w_terminate  = 1'b0;
        w_we         = 1'b0;
        w_waddr      = r_entry_count[ADDR_W-1:0];
        w_wdata      = {r_gap_counter, bus.eventTDATA};
        case (r_state)
            ST_IDLE: begin
                if (w_arm) begin
                    w_start      = 1'b1;
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_disarm) begin
                    w_state_next = ST_IDLE;
                end else if (w_trigger_hit) begin
                    w_first      = 1'b1;
                    w_we         = 1'b1;
                    w_waddr      = '0;
                    w_wdata      = {{SEQUENCE_GAP_WIDTH{1'b0}}, r_trigger_code};
                    w_state_next = ST_RECORDING;
                end
            end
            ST_RECORDING: begin
                if (w_recordable) begin
                    w_record = 1'b1;
                    w_we     = 1'b1;
                    if (w_end_code || w_last_slot) begin
                        w_terminate  = !w_disarm;
                        w_state_next = ST_DONE;
                    end
                end
                // A coincident disarm still lets the event land in RAM.
                if (w_disarm) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (w_disarm) begin
                    w_state_next = ST_IDLE;
                end else if (w_arm) begin
                    w_start      = 1'b1;
                    w_state_next = ST_ARMED;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge evrRxClk or negedge evrRxRst_n) begin
        if (!evrRxRst_n) begin
            r_state         <= ST_IDLE;
            r_entry_count   <= '0;
            r_gap_counter   <= '0;
            r_trigger_code  <= EVENTCODE_WIDTH'(8'h01);
            r_full          <= 1'b0;
            r_gap_saturated <= 1'b0;
            r_record_done   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_record_done <= w_terminate;
            if (w_start) begin
                r_entry_count   <= '0;
                r_full          <= 1'b0;
                r_gap_saturated <= 1'b0;
            end else if (w_first) begin
                r_entry_count <= CNT_W'(1);
                r_gap_counter <= '0;
            end else if (w_record) begin
                r_entry_count <= r_entry_count + CNT_W'(1);
                r_gap_counter <= '0;
                if (w_last_slot) begin
                    r_full <= 1'b1;
                end
            end else if (r_state == ST_RECORDING) begin
                if (r_gap_counter != SEQUENCE_GAP_MAX) begin
                    r_gap_counter <= r_gap_counter + 1'b1;
                end
                if (r_gap_counter >= SEQUENCE_GAP_MAX - 1'b1) begin
                    r_gap_saturated <= 1'b1;
                end
            end
            if (bus.csrStrobe && (w_cmd == CSR_SET_TRIGGER)) begin
                r_trigger_code <= bus.csrData[EVENTCODE_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge evrRxClk or negedge evrRxRst_n) begin
        if (!evrRxRst_n) begin
            r_read_address <= '0;
            r_read_select  <= 1'b0;
            r_status       <= '0;
            r_readback     <= '0;
        end else begin
            if (bus.csrStrobe && (w_cmd == CSR_SET_READ_ADDRESS)) begin
                r_read_address <= bus.csrData[ADDR_W-1:0];
                r_read_select  <= bus.csrData[24];
            end
            r_status <= {5'(ADDR_W), 3'b000, 12'(r_entry_count), 8'h00,
                         r_gap_saturated, r_full, r_state};
            // Second register stage behind the RAM read port.
            r_readback <= r_read_select ? 32'(w_ram_rdata[EVENTCODE_WIDTH-1:0])
                                        : 32'(w_ram_rdata[ENTRY_W-1:EVENTCODE_WIDTH]);
        end
    end

    evr_recorder_ram #(
        .DEPTH  (SEQUENCE_RAM_CAPACITY),
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (evrRxClk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_read_address),
        .o_rdata (w_ram_rdata)
    );

    assign bus.status     = r_status;
    assign bus.readback   = r_readback;
    assign bus.recordDone = r_record_done;
endmodule

// File: tb/tb_evr_sequence_recorder.sv
// Bench for evr_sequence_recorder: directed scenarios plus random capture rounds
// compared against a timestamp/queue model of the capture rules.
module tb_evr_sequence_recorder;
  import evr_sequence_recorder_pkg::*;

  localparam int CAP = 16;
  localparam int AW = 4;
  localparam logic [27:0] GMAX = 28'hFFFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  evr_sequence_recorder_if #(.EVENTCODE_WIDTH(8)) bus ();

  evr_sequence_recorder #(
    .SEQUENCE_RAM_CAPACITY(CAP),
    .EVENTCODE_WIDTH(8),
    .DEBUG("false")
  ) dut (
    .evrRxClk(clk),
    .evrRxRst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  // reference model: capture rules in terms of timestamps and an entry queue
  int m_state;
  logic [7:0] m_trig;
  int m_count;
  bit m_full, m_sat, m_done_exp;
  longint m_cyc, m_last;
  logic [31:0] m_status_exp;
  logic [35:0] exp_q[$];

  always @(negedge clk) if (bus.recordDone === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_trig = 8'h01; m_count = 0;
    m_full = 0; m_sat = 0; m_done_exp = 0;
    m_cyc = 0; m_last = 0; m_status_exp = '0;
    exp_q.delete();
  endtask

  task automatic model_restart();
    m_count = 0; m_full = 0; m_sat = 0; m_state = 1;
    exp_q.delete();
  endtask

  task automatic model(input bit v, input logic [7:0] c, input bit s, input logic [31:0] d);
    bit ctl, dis, arm;
    longint gap;
    m_status_exp = {5'(AW), 3'b0, 12'(m_count), 8'b0, m_sat, m_full, 2'(m_state)};
    m_done_exp = 0;
    m_cyc++;
    ctl = s && (d[31:30] == 2'h0);
    dis = ctl && d[1];
    arm = ctl && d[0] && !dis;
    case (m_state)
      0: if (arm) model_restart();
      1: begin
        if (dis) m_state = 0;
        else if (v && c == m_trig) begin
          exp_q.delete();
          exp_q.push_back({28'h0, m_trig});
          m_count = 1; m_last = m_cyc; m_state = 2;
        end
      end
      2: begin
        if (v && c != 8'h00) begin
          gap = m_cyc - m_last - 1;
          if (gap > longint'(GMAX)) gap = longint'(GMAX);
          exp_q.push_back({gap[27:0], c});
          m_count++; m_last = m_cyc;
          if (m_count == CAP) m_full = 1;
          if (c == 8'h7F || m_count == CAP) begin
            m_state = 3; m_done_exp = !dis;
          end
        end else if (m_cyc - m_last >= longint'(GMAX)) begin
          m_sat = 1;
        end
        if (dis) m_state = 0;
      end
      default: begin
        if (dis) m_state = 0;
        else if (arm) model_restart();
      end
    endcase
    if (s && d[31:30] == 2'h2) m_trig = d[7:0];
  endtask

  task automatic step(input bit v, input logic [7:0] c, input bit s, input logic [31:0] d);
    bus.eventTVALID = v; bus.eventTDATA = c; bus.csrStrobe = s; bus.csrData = d;
    @(posedge clk);
    model(v, c, s, d);
    #1;
    bus.eventTVALID = 1'b0; bus.eventTDATA = '0; bus.csrStrobe = 1'b0; bus.csrData = '0;
    chk("status", bus.status, m_status_exp);
    chk("recordDone", {31'b0, bus.recordDone}, {31'b0, m_done_exp});
  endtask

  task automatic ev(input logic [7:0] c);
    step(1'b1, c, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  task automatic csr(input logic [31:0] d);
    step(1'b0, 8'h00, 1'b1, d);
  endtask

  task automatic read_chk(input string tag, input int addr, input bit sel, input logic [31:0] exp);
    csr(32'h4000_0000 | (32'(sel) << 24) | 32'(addr));
    idle(2);
    chk(tag, bus.readback, exp);
  endtask

  task automatic read_all();
    for (int i = 0; i < exp_q.size(); i++) begin
      read_chk("rand_ev", i, 1'b1, {24'b0, exp_q[i][7:0]});
      read_chk("rand_gap", i, 1'b0, {4'b0, exp_q[i][35:8]});
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_status"}, bus.status, 32'h0);
    chk({tag, "_readback"}, bus.readback, 32'h0);
    chk({tag, "_recordDone"}, {31'b0, bus.recordDone}, 32'h0);
  endtask

  initial begin
    logic [7:0] code;
    int prev_done;
    bus.csrStrobe = 1'b0; bus.csrData = '0; bus.eventTVALID = 1'b0; bus.eventTDATA = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    idle(2);

    // T1: basic capture ending on end-of-table
    csr(32'h8000_0020);
    csr(32'h0000_0001);
    idle(3);
    ev(8'h20); ev(8'h21); idle(9); ev(8'h22); idle(2); ev(8'h7F);
    idle(1);
    chk("t1_status", bus.status, {5'd4, 3'b0, 12'd4, 8'b0, 1'b0, 1'b0, 2'd3});
    chk("t1_done_pulses", done_cnt, 32'd1);
    read_chk("t1_e0_ev", 0, 1'b1, 32'h20);
    read_chk("t1_e0_gap", 0, 1'b0, 32'h0);
    read_chk("t1_e1_ev", 1, 1'b1, 32'h21);
    read_chk("t1_e2_ev", 2, 1'b1, 32'h22);
    read_chk("t1_e2_gap", 2, 1'b0, 32'h9);
    read_chk("t1_e3_ev", 3, 1'b1, 32'h7F);
    read_chk("t1_e3_gap", 3, 1'b0, 32'h2);

    // T2: pre-trigger events and null codes are not recorded
    csr(32'h0000_0001);
    ev(8'h05); idle(1); ev(8'h00); ev(8'h20); ev(8'h00); idle(1); ev(8'h00); ev(8'h30);
    ev(8'h7F);
    idle(1);
    chk("t2_status", bus.status, {5'd4, 3'b0, 12'd3, 8'b0, 1'b0, 1'b0, 2'd3});
    read_chk("t2_e0_ev", 0, 1'b1, 32'h20);
    read_chk("t2_e1_ev", 1, 1'b1, 32'h30);
    read_chk("t2_e1_gap", 1, 1'b0, 32'h3);
    read_chk("t2_e2_gap", 2, 1'b0, 32'h0);

    // T3: fill the RAM; later events ignored
    csr(32'h0000_0001);
    ev(8'h20);
    for (int i = 1; i < 20; i++) ev(8'(i));
    idle(1);
    chk("t3_status", bus.status, {5'd4, 3'b0, 12'd16, 8'b0, 1'b0, 1'b1, 2'd3});
    chk("t3_done_pulses", done_cnt, 32'd3);
    read_chk("t3_e15_ev", 15, 1'b1, 32'h0F);
    read_chk("t3_e15_gap", 15, 1'b0, 32'h0);

    // T4: gap counter saturation
    csr(32'h0000_0001);
    ev(8'h20);
    force dut.r_gap_counter = GMAX - 28'd3;
    #1;
    release dut.r_gap_counter;
    m_last = m_cyc - longint'(GMAX - 28'd3);
    idle(5);
    ev(8'h40);
    csr(32'h0000_0002);
    idle(1);
    chk("t4_status", bus.status, {5'd4, 3'b0, 12'd2, 8'b0, 1'b1, 1'b0, 2'd0});
    read_chk("t4_e1_gap", 1, 1'b0, 32'h0FFF_FFFF);
    read_chk("t4_e1_ev", 1, 1'b1, 32'h40);

    // T5: disarm coincident with a recordable event
    prev_done = done_cnt;
    csr(32'h0000_0001);
    ev(8'h20); idle(2);
    step(1'b1, 8'h33, 1'b1, 32'h0000_0002);
    idle(1);
    chk("t5_status", bus.status, {5'd4, 3'b0, 12'd2, 8'b0, 1'b0, 1'b0, 2'd0});
    chk("t5_no_done", done_cnt, prev_done);
    read_chk("t5_e1_ev", 1, 1'b1, 32'h33);
    read_chk("t5_e1_gap", 1, 1'b0, 32'h2);

    // random capture rounds against the model
    for (int r = 0; r < 4; r++) begin
      csr({2'h2, 22'b0, 8'($urandom_range(1, 8'h7E))});
      csr(32'h0000_0001);
      for (int k = 0; k < 3; k++) ev(8'($urandom_range(0, 8'h7F)));
      ev(m_trig);
      for (int k = 0; k < 30; k++) begin
        idle($urandom_range(0, 3));
        code = ($urandom_range(0, 15) == 0) ? 8'h7F : 8'($urandom_range(0, 8'h7E));
        ev(code);
      end
      idle(1);
      read_all();
      csr(32'h0000_0002);
    end

    // T6: asynchronous reset in the middle of a capture
    csr(32'h0000_0001);
    ev(m_trig); ev(8'h21); ev(8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
